// File: rtl/pwm_multi_if.sv
// rtl/pwm_multi_if.sv - register-side and pin-side signal bundle for pwm_multi
//
// The center signal and its modport entries exist only when PWM_MULTI_CENTER_EN
// is defined.
interface pwm_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
);
    logic                      en;
    logic [WIDTH-1:0]          top;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       wr_en;
`ifdef PWM_MULTI_CENTER_EN
    logic                      center;
`endif
    logic [CHANNELS-1:0]       out;
    logic                      period_start;

`ifdef PWM_MULTI_CENTER_EN
    modport master (
        output en, top, duty, wr_en, center,
        input  out, period_start
    );
    modport slave (
        input  en, top, duty, wr_en, center,
        output out, period_start
    );
`else
    modport master (
        output en, top, duty, wr_en,
        input  out, period_start
    );
    modport slave (
        input  en, top, duty, wr_en,
        output out, period_start
    );
`endif
endinterface

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel phase-aligned PWM, optional center mode via PWM_MULTI_CENTER_EN
//
// One shared counter drives all channels. Duty values go through a shadow
// register and are copied into the active compare register only on the wrap
// edge, so a period in flight never sees a partial update. A write landing on
// the wrap edge itself bypasses the shadow and is used immediately.
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input logic        clk,
    input logic        rst,
    pwm_multi_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    ctr_q, ctr_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic                ps_q, ps_d;

    // Counter value the next enabled edge would load; a wrap is any edge whose
    // next counter value is zero, in both counting modes.
    logic [WIDTH-1:0]    ctr_next;
    logic                wrap;

`ifdef PWM_MULTI_CENTER_EN
    // dir_q: 0 = counting up, 1 = counting down.
    // center_q: mode in force for the current period, latched at each wrap.
    logic                dir_q, dir_d;
    logic                dir_next;
    logic                center_q, center_d;
`endif

    // Counter stepping for the mode in force this period
    always_comb begin
        ctr_next = '0;
`ifdef PWM_MULTI_CENTER_EN
        dir_next = 1'b0;
        if (center_q) begin
            if (bus.top == '0) begin
                ctr_next = '0;
                dir_next = 1'b0;
            end else if (!dir_q) begin
                // Turn around at top, or immediately if top dropped below ctr
                if (ctr_q >= bus.top) begin
                    ctr_next = ctr_q - ONE;
                    dir_next = 1'b1;
                end else begin
                    ctr_next = ctr_q + ONE;
                    dir_next = 1'b0;
                end
            end else if (ctr_q == '0) begin
                // Down at zero cannot follow a wrap; recover by heading up
                ctr_next = ONE;
                dir_next = 1'b0;
            end else begin
                ctr_next = ctr_q - ONE;
                dir_next = 1'b1;
            end
        end else
`endif
        begin
            if (ctr_q >= bus.top) begin
                ctr_next = '0;
            end else begin
                ctr_next = ctr_q + ONE;
            end
        end
    end

    assign wrap = (ctr_next == '0);

    // Next-state for shadow/active registers, counter, compare outputs and strobe
    always_comb begin
        ctr_d = ctr_q;
        out_d = out_q;
        ps_d  = 1'b0;
`ifdef PWM_MULTI_CENTER_EN
        dir_d    = dir_q;
        center_d = center_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (bus.wr_en[i]) begin
                shadow_d[i] = bus.duty[i*WIDTH +: WIDTH];
            end
        end

        if (bus.en) begin
            ctr_d = ctr_next;
            ps_d  = wrap;
            for (int i = 0; i < CHANNELS; i++) begin
                out_d[i] = (active_q[i] > ctr_q);
            end
            if (wrap) begin
                // shadow_d already carries a same-edge write, giving the bypass
                for (int i = 0; i < CHANNELS; i++) begin
                    active_d[i] = shadow_d[i];
                end
`ifdef PWM_MULTI_CENTER_EN
                dir_d    = 1'b0;
                center_d = bus.center;
`endif
            end else begin
`ifdef PWM_MULTI_CENTER_EN
                dir_d = dir_next;
`endif
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= '0;
            out_q <= '0;
            ps_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
`ifdef PWM_MULTI_CENTER_EN
            dir_q    <= 1'b0;
            center_q <= 1'b0;
`endif
        end else begin
            ctr_q <= ctr_d;
            out_q <= out_d;
            ps_q  <= ps_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
`ifdef PWM_MULTI_CENTER_EN
            dir_q    <= dir_d;
            center_q <= center_d;
`endif
        end
    end

    // Outputs come straight from flops
    assign bus.out          = out_q;
    assign bus.period_start = ps_q;
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator. Successor to the single-channel PWM block. It adds a runtime period, double-buffered per-channel duty registers that update only at period boundaries (glitch-free), a counter enable and a period-start strobe. All channels share one counter, so their edges are phase-aligned; an optional center-aligned mode is compile-time selectable. It sits between a register interface (duty/period writes) and motor, LED or servo output pins.

## Interface
- CHANNELS, 4, number of PWM outputs (≥1)
- WIDTH, 16, counter/duty/period width in bits (≥2)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  counter enable; 0 freezes counter and outputs
- top  in  WIDTH  terminal count; edge-aligned period = top+1 ticks; sampled live
- duty  in  CHANNELS*WIDTH  packed duty values, channel i = duty[i*WIDTH +: WIDTH]
- wr_en  in  CHANNELS  per-channel shadow-register write strobe
- center  in  1  center-aligned select (present only with PWM_MULTI_CENTER_EN)
- out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse in the first cycle of each period

## Operation
- Reset: ctr=0, dir=up, shadow[i]=0, active[i]=0, out=0, period_start=0.
- Shadow write: on an edge with wr_en[i]=1, shadow[i] ← duty slice i. Writes are accepted regardless of en.
- Edge-aligned counter (en=1):
  - If ctr ≥ top (wrap), ctr ← 0; otherwise ctr ← ctr+1.
  - If top is reduced below the current ctr, the counter wraps on the next edge.
  - If top=0, it wraps every cycle.
- Active load: on the wrap edge, active[i] ← shadow[i].
  - Bypass: if wr_en[i]=1 on the wrap edge, active[i] ← the new duty slice directly, and shadow[i] takes the same value.
- Compare: out[i] ← (active[i] > ctr), registered, evaluated every enabled edge.
  - active=0 gives out constant 0.
  - active > top gives out constant 1.
  - Otherwise out is high for exactly active[i] ticks per period.
- period_start ← wrap condition, registered. It is high for one cycle while ctr=0 after each wrap, and is not asserted out of reset until the first wrap.
- en=0: ctr, dir, active, out and period_start hold, except that period_start is forced 0. Resuming continues from the held ctr.
- rst mid-period: all state returns to reset values on that edge. Shadow contents are lost.

## Timing
- out and period_start lag the counter by one cycle. With ctr=c in cycle n, out[i] in cycle n+1 equals (active[i] > c).
- Duty write latency: a write in any cycle of period k takes effect from the first tick of period k+1. A write on the wrap edge of period k also takes effect in period k+1.
- top changes take effect on the next compare (ctr ≥ top) evaluation. There is no buffering of top.
- All outputs are driven directly by flops; no combinational paths run from inputs to outputs.

## Configuration
- Macro PWM_MULTI_CENTER_EN.
- Defined: the center port exists.
  - When center=1, the counter counts up 0→top, then down top→0. dir flips at top and at 0.
  - Period = 2·top ticks; top=0 holds ctr=0, and that cycle counts as a wrap.
  - The wrap/load/period_start condition is the edge where ctr=1 with dir=down (the next ctr is 0). The wrap edge therefore precedes the first ctr=0 cycle, and period_start is high during that cycle.
  - If top is reduced below ctr while counting up, dir flips to down on the next edge.
  - The same comparator gives symmetric pulses of 2·active[i]−1 ticks, centered on ctr=0.
  - center=0 behaves identically to edge-aligned mode.
  - Changing center takes effect at the next wrap; dir is reset to up at that point.
- Undefined: the center port is absent, there is no dir state, and the block is edge-aligned only.

## Test plan
- Reset/basic: rst 2 cycles, top=9, duty ch0=3 written (wr_en=1 at t0), en=1 → out[0] low for the rest of the current period. Thereafter each 10-cycle period shows high 3 cycles then low 7. period_start pulses every 10 cycles.
- Boundaries: ch1=0, ch2=10, ch3=9 with top=9 → out[1] always 0, out[2] always 1, out[3] high 9 of every 10 cycles.
- Double buffering: write ch0=5 mid-period, then ch0=7 on the wrap edge → next period shows 7 high ticks, never 5, with no glitch in the current period.
- Enable/top change: en=0 for 4 cycles mid-high → out and ctr frozen, period_start=0. Reduce top from 9 to 3 with ctr=6 → wrap on the next edge, then 4-cycle periods.
- Reset mid-operation: assert rst with out high and a pending shadow write → next cycle out=0, period_start=0. After release, out stays 0 until a new write plus a wrap.
- (PWM_MULTI_CENTER_EN) center=1, top=8, duty=3 → 16-cycle period, out high 5 cycles centered on ctr=0, period_start once per 16 cycles.
